// File: rtl/cluster_xbar_arb_pkg.sv
// Shared router packet layout: {v, x, y, c, payload} MSB-first, plus cluster-ID sizing.
package cluster_xbar_arb_pkg;

    localparam int DEF_D_W = 32;
    localparam int DEF_X_W = 4;
    localparam int DEF_Y_W = 4;

    // A single-PE cluster still carries a 1-bit cluster-ID field.
    function automatic int cid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pkt_w(input int x_w, input int y_w, input int c_w, input int d_w);
        return 1 + x_w + y_w + c_w + d_w;
    endfunction

    function automatic int v_pos(input int x_w, input int y_w, input int c_w, input int d_w);
        return pkt_w(x_w, y_w, c_w, d_w) - 1;
    endfunction

    function automatic int x_lsb(input int y_w, input int c_w, input int d_w);
        return y_w + c_w + d_w;
    endfunction

    function automatic int y_lsb(input int c_w, input int d_w);
        return c_w + d_w;
    endfunction

    function automatic int c_lsb(input int d_w);
        return d_w;
    endfunction

endpackage

// File: rtl/cluster_xbar_arb_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr; combinational grant.
// A grant left unaccepted (advance=0) is locked so the offer cannot change under the consumer.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] hold_idx;
    logic          hold_v;
    logic          any_req;

    assign any_req = |req;

    // Scan downward so the requester nearest to ptr is the last one written.
    always_comb begin
        int j;
        j        = 0;
        pick_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) pick_idx = IW'(j);
        end
    end

    assign grant_idx = hold_v ? hold_idx : pick_idx;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) grant[i] = any_req && (grant_idx == IW'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v   <= 1'b0;
            hold_idx <= '0;
        end else begin
            hold_v   <= any_req && !advance;
            hold_idx <= grant_idx;
        end
    end

    generate
        if (N > 1) begin : g_ptr
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                     ptr <= '0;
                else if (advance && any_req) ptr <= IW'((int'(grant_idx) + 1) % N);
            end
        end else begin : g_no_ptr
            assign ptr = '0;
        end
    endgenerate

endmodule

// File: rtl/cluster_xbar_arb.sv
// Cluster crossbar: per-lane ingress slots round-robined onto the router PE port, 1-cycle each way.
// Ingress stalls per lane via pe_ack while its slot is full; egress is registered and never stalls.
module cluster_xbar_arb
    import cluster_xbar_arb_pkg::*;
#(
    parameter int CLUSTER_SIZE = 4,
    parameter int D_W = DEF_D_W,
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W,
    parameter int C_W = cid_w(CLUSTER_SIZE),
    localparam int P_W = pkt_w(X_W, Y_W, C_W, D_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CLUSTER_SIZE*P_W-1:0] pe_out,
    output logic [CLUSTER_SIZE-1:0]     pe_ack,
    output logic [CLUSTER_SIZE*P_W-1:0] pe_in,
    output logic [CLUSTER_SIZE-1:0]     pe_in_v,
    input  logic [CLUSTER_SIZE-1:0]     pe_done,
    output logic [P_W-1:0]              rtr_i,
    input  logic                        rtr_ack,
    input  logic [P_W-1:0]              rtr_o,
    input  logic                        rtr_o_v,
    output logic [15:0]                 drop_cnt,
    output logic                        done_all
);

    localparam int IW    = (CLUSTER_SIZE > 1) ? $clog2(CLUSTER_SIZE) : 1;
    localparam int V_POS = v_pos(X_W, Y_W, C_W, D_W);
    localparam int C_LSB = c_lsb(D_W);

    logic [CLUSTER_SIZE-1:0] slot_v;
    logic [P_W-1:0]          slot_pkt [CLUSTER_SIZE];
    logic [CLUSTER_SIZE-1:0] grant;
    logic [CLUSTER_SIZE-1:0] drain;
    logic [IW-1:0]           grant_idx;
    logic [P_W-1:0]          sel_pkt;
    logic [C_W-1:0]          eg_c;
    logic                    eg_v;
    logic                    eg_hit;

    rr_arbiter #(.N(CLUSTER_SIZE)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (slot_v),
        .advance   (rtr_ack),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign drain = grant & {CLUSTER_SIZE{rtr_ack}};

    // A slot being drained this edge can take the next packet on the same edge.
    always_comb begin
        pe_ack = '0;
        for (int k = 0; k < CLUSTER_SIZE; k++)
            pe_ack[k] = !rst && pe_out[k*P_W + V_POS] && (!slot_v[k] || drain[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v <= '0;
            for (int k = 0; k < CLUSTER_SIZE; k++) slot_pkt[k] <= '0;
        end else begin
            for (int k = 0; k < CLUSTER_SIZE; k++) begin
                if (pe_ack[k]) begin
                    slot_v[k]   <= 1'b1;
                    slot_pkt[k] <= pe_out[k*P_W +: P_W];
                end else if (drain[k]) begin
                    slot_v[k] <= 1'b0;
                end
            end
        end
    end

    generate
        if (CLUSTER_SIZE == 1) begin : g_one
            assign sel_pkt = slot_pkt[0];
        end else begin : g_mux
            assign sel_pkt = slot_pkt[grant_idx];
        end
    endgenerate

    assign rtr_i = (|slot_v) ? sel_pkt : '0;

    assign eg_v   = rtr_o_v && rtr_o[V_POS];
    assign eg_c   = rtr_o[C_LSB +: C_W];
    assign eg_hit = eg_v && (int'(eg_c) < CLUSTER_SIZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_in_v  <= '0;
            pe_in    <= '0;
            drop_cnt <= '0;
            done_all <= 1'b0;
        end else begin
            for (int k = 0; k < CLUSTER_SIZE; k++) begin
                pe_in_v[k] <= eg_hit && (eg_c == C_W'(k));
                if (eg_hit && (eg_c == C_W'(k))) pe_in[k*P_W +: P_W] <= rtr_o;
            end
            if (eg_v && !eg_hit && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            done_all <= (&pe_done) && !(|slot_v) && !eg_v;
        end
    end

endmodule
